// File: rtl/coeff_load_controller.sv
// Coefficient load controller: walks the operator through entering a polynomial
// degree, coefficients A..E (x^4..x^0), step value N and sign option S with a
// debounced go key, then starts the plotter and waits for it to finish.
// Optional feature macro: SKIP_UNUSED_COEFF_EN -- zeroes coefficients above the
// loaded degree and skips their load/wait states.
module coeff_load_controller #(
    parameter int MAX_DEGREE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [6:0]        constant,
    input  logic              plot_done,
    output logic [5:0]        current_state,
    output logic [2:0]        degree,
    output logic signed [6:0] coef_a,
    output logic signed [6:0] coef_b,
    output logic signed [6:0] coef_c,
    output logic signed [6:0] coef_d,
    output logic signed [6:0] coef_e,
    output logic [5:0]        n_val,
    output logic              s_neg,
    output logic              start_plot
);

    typedef enum logic [5:0] {
        INITIALIZATION   = 6'd0,
        LOAD_DEGREE      = 6'd1,
        LOAD_DEGREE_WAIT = 6'd2,
        LOAD_A           = 6'd3,
        A_WAIT           = 6'd4,
        LOAD_B           = 6'd5,
        B_WAIT           = 6'd6,
        LOAD_C           = 6'd7,
        C_WAIT           = 6'd8,
        LOAD_D           = 6'd9,
        D_WAIT           = 6'd10,
        LOAD_E           = 6'd11,
        E_WAIT           = 6'd12,
        LOAD_N           = 6'd13,
        N_WAIT           = 6'd14,
        LOAD_S           = 6'd15,
        S_WAIT           = 6'd16,
        PLOT             = 6'd17,
        PLOT_FINISHED    = 6'd18
    } state_t;

    localparam logic [2:0] MAX_DEG = 3'(MAX_DEGREE);

    state_t     state;
    logic [2:0] clamped_degree;
    state_t     first_coef;

    assign current_state = state;

    // Degree entry is clamped to the highest supported degree.
    always_comb begin
        clamped_degree = (constant[2:0] > MAX_DEG) ? MAX_DEG : constant[2:0];
    end

    // Pick the first coefficient state to visit after the degree is entered.
    always_comb begin
`ifdef SKIP_UNUSED_COEFF_EN
        case (degree)
            3'd4:    first_coef = LOAD_A;
            3'd3:    first_coef = LOAD_B;
            3'd2:    first_coef = LOAD_C;
            3'd1:    first_coef = LOAD_D;
            default: first_coef = LOAD_E;
        endcase
`else
        first_coef = LOAD_A;
`endif
    end

    // Load sequencer: each LOAD state captures on go, each WAIT state advances on release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= INITIALIZATION;
            degree     <= '0;
            coef_a     <= '0;
            coef_b     <= '0;
            coef_c     <= '0;
            coef_d     <= '0;
            coef_e     <= '0;
            n_val      <= '0;
            s_neg      <= 1'b0;
            start_plot <= 1'b0;
        end else begin
            start_plot <= 1'b0;
            case (state)
                INITIALIZATION: state <= LOAD_DEGREE;
                LOAD_DEGREE: if (go) begin
                    degree <= clamped_degree;
                    state  <= LOAD_DEGREE_WAIT;
                end
                LOAD_DEGREE_WAIT: if (!go) begin
                    state <= first_coef;
`ifdef SKIP_UNUSED_COEFF_EN
                    if (degree < 3'd4) coef_a <= '0;
                    if (degree < 3'd3) coef_b <= '0;
                    if (degree < 3'd2) coef_c <= '0;
                    if (degree < 3'd1) coef_d <= '0;
`endif
                end
                LOAD_A: if (go) begin
                    coef_a <= constant;
                    state  <= A_WAIT;
                end
                A_WAIT: if (!go) state <= LOAD_B;
                LOAD_B: if (go) begin
                    coef_b <= constant;
                    state  <= B_WAIT;
                end
                B_WAIT: if (!go) state <= LOAD_C;
                LOAD_C: if (go) begin
                    coef_c <= constant;
                    state  <= C_WAIT;
                end
                C_WAIT: if (!go) state <= LOAD_D;
                LOAD_D: if (go) begin
                    coef_d <= constant;
                    state  <= D_WAIT;
                end
                D_WAIT: if (!go) state <= LOAD_E;
                LOAD_E: if (go) begin
                    coef_e <= constant;
                    state  <= E_WAIT;
                end
                E_WAIT: if (!go) state <= LOAD_N;
                LOAD_N: if (go) begin
                    n_val <= constant[5:0];
                    state <= N_WAIT;
                end
                N_WAIT: if (!go) state <= LOAD_S;
                LOAD_S: if (go) begin
                    s_neg <= constant[0];
                    state <= S_WAIT;
                end
                S_WAIT: if (!go) begin
                    state      <= PLOT;
                    start_plot <= 1'b1;
                end
                PLOT: if (plot_done) state <= PLOT_FINISHED;
                PLOT_FINISHED: if (go) state <= LOAD_DEGREE_WAIT;
                default: state <= INITIALIZATION;
            endcase
        end
    end

endmodule

// File: tb/tb_coeff_load_controller.sv
// Directed testbench for coeff_load_controller: reset, degree clamp with a long
// key hold, ignored plot_done/go, asynchronous reset mid-handshake, then a
// table-driven full pass including plot and re-edit.
module tb_coeff_load_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic [6:0]  constant;
    logic        plot_done;
    logic [5:0]  current_state;
    logic [2:0]  degree;
    logic [6:0]  coef_a, coef_b, coef_c, coef_d, coef_e;
    logic [5:0]  n_val;
    logic        s_neg;
    logic        start_plot;

    int unsigned errors = 0;
    int unsigned checks = 0;

    coeff_load_controller #(.MAX_DEGREE(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .constant      (constant),
        .plot_done     (plot_done),
        .current_state (current_state),
        .degree        (degree),
        .coef_a        (coef_a),
        .coef_b        (coef_b),
        .coef_c        (coef_c),
        .coef_d        (coef_d),
        .coef_e        (coef_e),
        .n_val         (n_val),
        .s_neg         (s_neg),
        .start_plot    (start_plot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       go;
        logic [6:0] cst;
        logic       pd;
        logic [5:0] st;
        logic [2:0] deg;
        logic [6:0] a, b, c, d, e;
        logic [5:0] n;
        logic       s;
        logic       sp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic g, input logic [6:0] cst, input logic pd,
                       input logic [5:0] st, input logic [2:0] deg,
                       input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                       input logic [6:0] d, input logic [6:0] e,
                       input logic [5:0] n, input logic s, input logic sp);
        vec_t v;
        v.go = g; v.cst = cst; v.pd = pd; v.st = st; v.deg = deg;
        v.a = a; v.b = b; v.c = c; v.d = d; v.e = e;
        v.n = n; v.s = s; v.sp = sp;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs, advance one clock, sample 1 ns after the edge.
    task automatic step(input logic g, input logic [6:0] cst, input logic pd);
        go = g; constant = cst; plot_done = pd;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [45:0] out_vec();
        return {degree, coef_a, coef_b, coef_c, coef_d, coef_e, n_val, s_neg, start_plot};
    endfunction

    initial begin
        reset = 1'b1; go = 1'b0; constant = '0; plot_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", current_state, 0);
        check("reset outputs", out_vec(), 46'h0);
        reset = 1'b0;
        step(0, 7'h00, 0);
        check("init to load_degree", current_state, 1);

        // Degree clamp and a 50-cycle key hold: one capture only.
        step(1, 7'h07, 0);
        check("clamp state", current_state, 2);
        check("clamp degree", degree, 4);
        for (int i = 0; i < 49; i++) begin
            step(1, 7'h01, 0);
            check("hold state", current_state, 2);
            check("hold degree", degree, 4);
        end
        step(0, 7'h01, 0);
        check("release to load_a", current_state, 3);
        step(0, 7'h33, 1);
        check("plot_done ignored state", current_state, 3);
        check("plot_done ignored coef_a", coef_a, 0);
        step(1, 7'h15, 0);
        check("capture a state", current_state, 4);
        check("capture a", coef_a, 7'h15);
        step(0, 7'h15, 0);
        step(1, 7'h2A, 0);
        check("capture b", coef_b, 7'h2A);
        step(0, 7'h2A, 0);
        step(1, 7'h03, 0);
        check("c_wait state", current_state, 8);
        check("capture c", coef_c, 7'h03);

        // Asynchronous reset while go is still held in C_WAIT.
        #2;
        reset = 1'b1;
        #1;
        check("async reset state", current_state, 0);
        check("async reset coefs", {coef_a, coef_b, coef_c, coef_d, coef_e}, 35'h0);
        check("async reset outputs", out_vec(), 46'h0);
        @(posedge clk);
        #1;
        check("reset held state", current_state, 0);
        reset = 1'b0;
        step(0, 7'h00, 0);
        check("post reset state", current_state, 1);

`ifndef SKIP_UNUSED_COEFF_EN
        //  go  cst    pd  st  deg  a      b      c      d      e      n      s  sp
        add(1, 7'h02, 0,  2, 2, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 6'h00, 0, 0);
        add(0, 7'h02, 0,  3, 2, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 6'h00, 0, 0);
        add(1, 7'h05, 0,  4, 2, 7'h05, 7'h00, 7'h00, 7'h00, 7'h00, 6'h00, 0, 0);
        add(0, 7'h05, 0,  5, 2, 7'h05, 7'h00, 7'h00, 7'h00, 7'h00, 6'h00, 0, 0);
        add(1, 7'h7D, 0,  6, 2, 7'h05, 7'h7D, 7'h00, 7'h00, 7'h00, 6'h00, 0, 0);
        add(0, 7'h7D, 0,  7, 2, 7'h05, 7'h7D, 7'h00, 7'h00, 7'h00, 6'h00, 0, 0);
        add(1, 7'h01, 0,  8, 2, 7'h05, 7'h7D, 7'h01, 7'h00, 7'h00, 6'h00, 0, 0);
        add(0, 7'h01, 0,  9, 2, 7'h05, 7'h7D, 7'h01, 7'h00, 7'h00, 6'h00, 0, 0);
        add(1, 7'h00, 0, 10, 2, 7'h05, 7'h7D, 7'h01, 7'h00, 7'h00, 6'h00, 0, 0);
        add(0, 7'h00, 0, 11, 2, 7'h05, 7'h7D, 7'h01, 7'h00, 7'h00, 6'h00, 0, 0);
        add(1, 7'h40, 0, 12, 2, 7'h05, 7'h7D, 7'h01, 7'h00, 7'h40, 6'h00, 0, 0);
        add(0, 7'h40, 0, 13, 2, 7'h05, 7'h7D, 7'h01, 7'h00, 7'h40, 6'h00, 0, 0);
        add(1, 7'h0A, 0, 14, 2, 7'h05, 7'h7D, 7'h01, 7'h00, 7'h40, 6'h0A, 0, 0);
        add(0, 7'h0A, 0, 15, 2, 7'h05, 7'h7D, 7'h01, 7'h00, 7'h40, 6'h0A, 0, 0);
        add(1, 7'h01, 0, 16, 2, 7'h05, 7'h7D, 7'h01, 7'h00, 7'h40, 6'h0A, 1, 0);
        add(0, 7'h01, 0, 17, 2, 7'h05, 7'h7D, 7'h01, 7'h00, 7'h40, 6'h0A, 1, 1);
        add(0, 7'h01, 0, 17, 2, 7'h05, 7'h7D, 7'h01, 7'h00, 7'h40, 6'h0A, 1, 0);
        add(1, 7'h55, 0, 17, 2, 7'h05, 7'h7D, 7'h01, 7'h00, 7'h40, 6'h0A, 1, 0);
        add(0, 7'h55, 1, 18, 2, 7'h05, 7'h7D, 7'h01, 7'h00, 7'h40, 6'h0A, 1, 0);
        add(0, 7'h55, 0, 18, 2, 7'h05, 7'h7D, 7'h01, 7'h00, 7'h40, 6'h0A, 1, 0);
        add(1, 7'h03, 0,  2, 2, 7'h05, 7'h7D, 7'h01, 7'h00, 7'h40, 6'h0A, 1, 0);
        add(0, 7'h03, 0,  3, 2, 7'h05, 7'h7D, 7'h01, 7'h00, 7'h40, 6'h0A, 1, 0);
        add(1, 7'h11, 0,  4, 2, 7'h11, 7'h7D, 7'h01, 7'h00, 7'h40, 6'h0A, 1, 0);
`else
        //  go  cst    pd  st  deg  a      b      c      d      e      n      s  sp
        add(1, 7'h02, 0,  2, 2, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 6'h00, 0, 0);
        add(0, 7'h02, 0,  7, 2, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 6'h00, 0, 0);
        add(1, 7'h01, 0,  8, 2, 7'h00, 7'h00, 7'h01, 7'h00, 7'h00, 6'h00, 0, 0);
        add(0, 7'h01, 0,  9, 2, 7'h00, 7'h00, 7'h01, 7'h00, 7'h00, 6'h00, 0, 0);
        add(1, 7'h7F, 0, 10, 2, 7'h00, 7'h00, 7'h01, 7'h7F, 7'h00, 6'h00, 0, 0);
        add(0, 7'h7F, 0, 11, 2, 7'h00, 7'h00, 7'h01, 7'h7F, 7'h00, 6'h00, 0, 0);
        add(1, 7'h40, 0, 12, 2, 7'h00, 7'h00, 7'h01, 7'h7F, 7'h40, 6'h00, 0, 0);
        add(0, 7'h40, 0, 13, 2, 7'h00, 7'h00, 7'h01, 7'h7F, 7'h40, 6'h00, 0, 0);
        add(1, 7'h0A, 0, 14, 2, 7'h00, 7'h00, 7'h01, 7'h7F, 7'h40, 6'h0A, 0, 0);
        add(0, 7'h0A, 0, 15, 2, 7'h00, 7'h00, 7'h01, 7'h7F, 7'h40, 6'h0A, 0, 0);
        add(1, 7'h01, 0, 16, 2, 7'h00, 7'h00, 7'h01, 7'h7F, 7'h40, 6'h0A, 1, 0);
        add(0, 7'h01, 0, 17, 2, 7'h00, 7'h00, 7'h01, 7'h7F, 7'h40, 6'h0A, 1, 1);
        add(1, 7'h55, 0, 17, 2, 7'h00, 7'h00, 7'h01, 7'h7F, 7'h40, 6'h0A, 1, 0);
        add(0, 7'h55, 1, 18, 2, 7'h00, 7'h00, 7'h01, 7'h7F, 7'h40, 6'h0A, 1, 0);
        add(1, 7'h03, 0,  2, 2, 7'h00, 7'h00, 7'h01, 7'h7F, 7'h40, 6'h0A, 1, 0);
        add(0, 7'h03, 0,  7, 2, 7'h00, 7'h00, 7'h01, 7'h7F, 7'h40, 6'h0A, 1, 0);
        add(1, 7'h22, 0,  8, 2, 7'h00, 7'h00, 7'h22, 7'h7F, 7'h40, 6'h0A, 1, 0);
`endif

        foreach (tbl[i]) begin
            step(tbl[i].go, tbl[i].cst, tbl[i].pd);
            check($sformatf("row %0d state", i), current_state, tbl[i].st);
            check($sformatf("row %0d outputs", i), out_vec(),
                  {tbl[i].deg, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].e,
                   tbl[i].n, tbl[i].s, tbl[i].sp});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/coeff_load_controller.md
COEFF_LOAD_CONTROLLER -- requirements
Module: coeff_load_controller

Interface
REQ-001 SHALL have parameter MAX_DEGREE, default 4, meaning the highest accepted polynomial degree (range 1..4).
REQ-002 SHALL have port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: go  input  1  load key, active-high, already debounced and synchronous to clk.
REQ-005 SHALL have port: constant  input  7  switch value, two's complement for coefficients, unsigned otherwise.
REQ-006 SHALL have port: plot_done  input  1  plotter finished, single-cycle pulse or level.
REQ-007 SHALL have port: current_state  output  6  state code for the input display.
REQ-008 SHALL have port: degree  output  3  loaded degree.
REQ-009 SHALL have ports: coef_a, coef_b, coef_c, coef_d, coef_e  output  7 each  signed coefficients of x^4..x^0.
REQ-010 SHALL have ports: n_val  output  6  unsigned step value; s_neg  output  1  sign option.
REQ-011 SHALL have port: start_plot  output  1  one-cycle plot-start pulse.

Function
REQ-012 SHALL encode states as: INITIALIZATION=0, LOAD_DEGREE=1, LOAD_DEGREE_WAIT=2, LOAD_A=3, A_WAIT=4, LOAD_B=5, B_WAIT=6, LOAD_C=7, C_WAIT=8, LOAD_D=9, D_WAIT=10, LOAD_E=11, E_WAIT=12, LOAD_N=13, N_WAIT=14, LOAD_S=15, S_WAIT=16, PLOT=17, PLOT_FINISHED=18.
REQ-013 SHALL drive current_state directly from the state register, with no added latency.
REQ-014 SHALL move INITIALIZATION to LOAD_DEGREE unconditionally after one cycle.
REQ-015 Handshake: in any LOAD_x state, on a cycle with go=1, SHALL capture constant into the target register on that edge and enter x_WAIT.
REQ-016 SHALL remain in x_WAIT while go=1, and on the first cycle with go=0 SHALL advance to the next LOAD state; each press captures exactly once.
REQ-017 Degree capture: degree <= min(constant[2:0], MAX_DEGREE), unsigned.
REQ-018 Order after LOAD_DEGREE_WAIT: first coefficient LOAD state (see REQ-026), then A..E in sequence, then LOAD_N.
REQ-019 n_val SHALL be constant[5:0]; s_neg SHALL be constant[0].
REQ-020 SHALL exit S_WAIT into PLOT and assert start_plot for exactly the first cycle spent in PLOT.
REQ-021 SHALL hold PLOT until plot_done=1, then enter PLOT_FINISHED; plot_done SHALL be ignored in all other states.
REQ-022 In PLOT_FINISHED, go=1 SHALL enter LOAD_DEGREE_WAIT with degree unchanged (re-edit path); release SHALL then proceed as in REQ-018.
REQ-023 Registers not written during a pass SHALL keep their previous values, except as stated in REQ-026.
REQ-024 go held high across a WAIT->LOAD boundary is impossible by construction; go asserted in PLOT SHALL be ignored.

Reset
REQ-025 On reset=1, SHALL immediately set state to INITIALIZATION and clear all outputs to 0 (degree=0, coef_*=0, n_val=0, s_neg=0, start_plot=0), including reset mid-handshake or mid-plot; reset SHALL not wait for go release.

Configuration
REQ-026 Macro SKIP_UNUSED_COEFF_EN: when defined, coefficients of powers above degree SHALL be cleared to 0 on leaving LOAD_DEGREE_WAIT and their LOAD/WAIT states skipped, so the first coefficient state is LOAD_(E-degree); when undefined, all of A..E SHALL always be loaded, starting at LOAD_A.

Verification
REQ-027 Reset mid-pass: reset in LOAD_C_WAIT -> state=0 and all coef_*=0 on the same cycle, then state=1 one cycle after release.
REQ-028 Full pass with macro undefined: degree 2, A=5, B=-3 (7'h7D), C=1, D=0, E=-64, N=10, S=1 -> registers read back exactly; start_plot is high for one cycle; plot_done -> state=18.
REQ-029 With SKIP_UNUSED_COEFF_EN and degree=2 -> state goes 2->7, coef_a=coef_b=0, and the next two presses load C and D.
REQ-030 Degree clamp: constant=7 -> degree=4; go held 50 cycles -> one capture and state stays 2 until release.
REQ-031 plot_done pulse in LOAD_A is ignored -> state remains 3; go in PLOT -> state remains 17.
REQ-032 Re-edit: go in PLOT_FINISHED -> state 2, degree kept, previous coefficients retained until overwritten.
